// File: rtl/control_sequencer_if.sv
// Signal bundle between the hardwired control sequencer and the datapath CPU:
// status inputs towards the sequencer and every control strobe it drives back.
interface control_sequencer_if #(
    parameter int OPW = 5
);
    logic           run_in;
    logic [OPW-1:0] ir_op;
    logic           mem_ready;
    logic [9:0]     bus_sel;
    logic [9:0]     reg_ld;
    logic [2:0]     gr_sel;
    logic [12:0]    alu_op;
    logic           IncPC;
    logic           Read;
    logic           read_mem;
    logic           CON_RESET;
    logic           running;
    logic           halted;
    logic [2:0]     step;

    modport master (
        input  run_in, ir_op, mem_ready,
        output bus_sel, reg_ld, gr_sel, alu_op, IncPC, Read, read_mem,
               CON_RESET, running, halted, step
    );

    modport slave (
        output run_in, ir_op, mem_ready,
        input  bus_sel, reg_ld, gr_sel, alu_op, IncPC, Read, read_mem,
               CON_RESET, running, halted, step
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired micro-sequencer: fetch in T0-T2, then opcode-driven execute steps T3-T6.
// Control strobes are a pure decode of the registered state (plus the IR opcode from T3 on).
module control_sequencer #(
    parameter int OPW           = 5,
    parameter int MULDIV_CYCLES = 1,
    parameter int MEM_TIMEOUT   = 0
) (
    input  logic                clk,
    input  logic                reset,
    control_sequencer_if.master cs
);
    typedef enum logic [3:0] {
        S_RST, S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_NONE, C_LDI, C_RTYPE, C_IMM, C_MULDIV, C_UNARY, C_MOVE, C_HALT
    } cls_t;

    localparam logic [OPW-1:0] OP_LDI  = OPW'(5'b00001);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
    localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00101);
    localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
    localparam logic [OPW-1:0] OP_ROR  = OPW'(5'b00111);
    localparam logic [OPW-1:0] OP_ROL  = OPW'(5'b01000);
    localparam logic [OPW-1:0] OP_SHR  = OPW'(5'b01001);
    localparam logic [OPW-1:0] OP_SHRA = OPW'(5'b01010);
    localparam logic [OPW-1:0] OP_SHL  = OPW'(5'b01011);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(5'b01100);
    localparam logic [OPW-1:0] OP_ANDI = OPW'(5'b01101);
    localparam logic [OPW-1:0] OP_ORI  = OPW'(5'b01110);
    localparam logic [OPW-1:0] OP_DIV  = OPW'(5'b01111);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(5'b10000);
    localparam logic [OPW-1:0] OP_NEG  = OPW'(5'b10001);
    localparam logic [OPW-1:0] OP_NOT  = OPW'(5'b10010);
    localparam logic [OPW-1:0] OP_IN   = OPW'(5'b10110);
    localparam logic [OPW-1:0] OP_OUT  = OPW'(5'b10111);
    localparam logic [OPW-1:0] OP_MFHI = OPW'(5'b11000);
    localparam logic [OPW-1:0] OP_MFLO = OPW'(5'b11001);
    localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

    // Bit positions inside the control vectors
    localparam int BS_BA = 9, BS_R = 8, BS_C = 7, BS_IN = 6, BS_MDR = 5;
    localparam int BS_ZLO = 3, BS_ZHI = 2, BS_LO = 1, BS_HI = 0;
    localparam int LD_OUT = 9, LD_R = 8, LD_MDR = 7, LD_MAR = 6, LD_Y = 5;
    localparam int LD_Z = 4, LD_IR = 3, LD_PC = 2, LD_LO = 1, LD_HI = 0;
    localparam int GR_C = 2, GR_B = 1, GR_A = 0;
    localparam logic [12:0] ALU_NOT  = 13'h1000, ALU_NEG = 13'h0800, ALU_ROL = 13'h0400;
    localparam logic [12:0] ALU_ROR  = 13'h0200, ALU_SHL = 13'h0100, ALU_SHRA = 13'h0080;
    localparam logic [12:0] ALU_SHR  = 13'h0040, ALU_DIV = 13'h0020, ALU_MUL = 13'h0010;
    localparam logic [12:0] ALU_SUB  = 13'h0008, ALU_ADD = 13'h0004, ALU_OR = 13'h0002;
    localparam logic [12:0] ALU_AND  = 13'h0001;

    localparam int MD_W = $clog2(MULDIV_CYCLES + 1) + 1;
    localparam int MT_W = $clog2(MEM_TIMEOUT + 1) + 1;
    localparam logic [MD_W-1:0] MD_LAST = MD_W'(MULDIV_CYCLES - 1);
    localparam logic [MT_W-1:0] MT_LAST = (MEM_TIMEOUT > 0) ? MT_W'(MEM_TIMEOUT - 1) : '0;

    function automatic cls_t op_class(input logic [OPW-1:0] op);
        case (op)
            OP_LDI:                                  return C_LDI;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL:         return C_RTYPE;
            OP_ADDI, OP_ANDI, OP_ORI:                return C_IMM;
            OP_DIV, OP_MUL:                          return C_MULDIV;
            OP_NEG, OP_NOT:                          return C_UNARY;
            OP_IN, OP_OUT, OP_MFHI, OP_MFLO:         return C_MOVE;
            OP_HALT:                                 return C_HALT;
            default:                                 return C_NONE;
        endcase
    endfunction

    // Immediate forms reuse the ALU function of their register counterpart
    function automatic logic [12:0] alu_of(input logic [OPW-1:0] op);
        case (op)
            OP_ADD, OP_ADDI: return ALU_ADD;
            OP_SUB:          return ALU_SUB;
            OP_AND, OP_ANDI: return ALU_AND;
            OP_OR, OP_ORI:   return ALU_OR;
            OP_ROR:          return ALU_ROR;
            OP_ROL:          return ALU_ROL;
            OP_SHR:          return ALU_SHR;
            OP_SHRA:         return ALU_SHRA;
            OP_SHL:          return ALU_SHL;
            OP_DIV:          return ALU_DIV;
            OP_MUL:          return ALU_MUL;
            OP_NEG:          return ALU_NEG;
            OP_NOT:          return ALU_NOT;
            default:         return 13'h0000;
        endcase
    endfunction

    state_t            state_r, state_nx_s, boundary_s;
    logic [OPW-1:0]    op_r, op_s;
    logic [MD_W-1:0]   md_cnt_r;
    logic [MT_W-1:0]   mem_cnt_r;
    cls_t              cls_s;
    logic [12:0]       alu_s;
    logic              mem_to_s;

    logic [9:0]  bus_sel_s, reg_ld_s;
    logic [2:0]  gr_sel_s, step_s;
    logic [12:0] alu_op_s;
    logic        inc_pc_s, read_s, con_reset_s, running_s, halted_s;

    // The IR opcode is live in T3; later steps use the copy captured there
    assign op_s     = (state_r == S_T3) ? cs.ir_op : op_r;
    assign cls_s    = op_class(op_s);
    assign alu_s    = alu_of(op_s);
    assign mem_to_s = (MEM_TIMEOUT > 0) && (mem_cnt_r == MT_LAST);

    // State, captured opcode and stall/iteration counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= S_RST;
            op_r      <= '0;
            md_cnt_r  <= '0;
            mem_cnt_r <= '0;
        end else begin
            state_r   <= state_nx_s;
            op_r      <= (state_r == S_T3) ? cs.ir_op : op_r;
            md_cnt_r  <= (state_r == S_T4 && state_nx_s == S_T4) ? md_cnt_r + MD_W'(1) : '0;
            mem_cnt_r <= (state_r == S_T1 && state_nx_s == S_T1) ? mem_cnt_r + MT_W'(1) : '0;
        end
    end

    // Next-state: run_in is only consulted at instruction boundaries
    always_comb begin
        state_nx_s = state_r;
        boundary_s = cs.run_in ? S_T0 : S_IDLE;
        case (state_r)
            S_RST:  state_nx_s = S_IDLE;
            S_IDLE: begin
                if (cs.run_in) state_nx_s = S_T0;
                else           state_nx_s = S_IDLE;
            end
            S_T0:   state_nx_s = S_T1;
            S_T1: begin
                if (cs.mem_ready || mem_to_s) state_nx_s = S_T2;
                else                          state_nx_s = S_T1;
            end
            S_T2:   state_nx_s = S_T3;
            S_T3: begin
                case (cls_s)
                    C_HALT:                                   state_nx_s = S_HALT;
                    C_LDI, C_RTYPE, C_IMM, C_MULDIV, C_UNARY: state_nx_s = S_T4;
                    default:                                  state_nx_s = boundary_s;
                endcase
            end
            S_T4: begin
                case (cls_s)
                    C_LDI, C_RTYPE, C_IMM: state_nx_s = S_T5;
                    C_MULDIV: state_nx_s = (md_cnt_r == MD_LAST) ? S_T5 : S_T4;
                    default:  state_nx_s = boundary_s;
                endcase
            end
            S_T5: begin
                if (cls_s == C_MULDIV) state_nx_s = S_T6;
                else                   state_nx_s = boundary_s;
            end
            S_T6:   state_nx_s = boundary_s;
            S_HALT: state_nx_s = S_HALT;
            default: state_nx_s = S_RST;
        endcase
    end

    // Control strobe decode from the current step and instruction class
    always_comb begin
        bus_sel_s   = 10'b0;
        reg_ld_s    = 10'b0;
        gr_sel_s    = 3'b0;
        alu_op_s    = 13'b0;
        inc_pc_s    = 1'b0;
        read_s      = 1'b0;
        con_reset_s = 1'b0;
        running_s   = 1'b0;
        halted_s    = 1'b0;
        step_s      = 3'd7;
        case (state_r)
            S_RST:  con_reset_s = 1'b1;
            S_IDLE: step_s = 3'd7;
            S_T0: begin
                step_s = 3'd0; running_s = 1'b1; inc_pc_s = 1'b1;
                reg_ld_s[LD_MAR] = 1'b1; reg_ld_s[LD_PC] = 1'b1;
            end
            S_T1: begin
                step_s = 3'd1; running_s = 1'b1; read_s = 1'b1;
                reg_ld_s[LD_MDR] = 1'b1;
            end
            S_T2: begin
                step_s = 3'd2; running_s = 1'b1;
                bus_sel_s[BS_MDR] = 1'b1; reg_ld_s[LD_IR] = 1'b1;
            end
            S_T3: begin
                step_s = 3'd3; running_s = 1'b1;
                case (cls_s)
                    C_LDI: begin
                        gr_sel_s[GR_B] = 1'b1; bus_sel_s[BS_BA] = 1'b1; reg_ld_s[LD_Y] = 1'b1;
                    end
                    C_RTYPE, C_IMM: begin
                        gr_sel_s[GR_B] = 1'b1; bus_sel_s[BS_R] = 1'b1; reg_ld_s[LD_Y] = 1'b1;
                    end
                    C_MULDIV: begin
                        gr_sel_s[GR_A] = 1'b1; bus_sel_s[BS_R] = 1'b1; reg_ld_s[LD_Y] = 1'b1;
                    end
                    C_UNARY: begin
                        gr_sel_s[GR_B] = 1'b1; bus_sel_s[BS_R] = 1'b1;
                        alu_op_s = alu_s; reg_ld_s[LD_Z] = 1'b1;
                    end
                    C_MOVE: begin
                        gr_sel_s[GR_A] = 1'b1;
                        case (op_s)
                            OP_IN:   begin bus_sel_s[BS_IN] = 1'b1; reg_ld_s[LD_R] = 1'b1;   end
                            OP_OUT:  begin bus_sel_s[BS_R]  = 1'b1; reg_ld_s[LD_OUT] = 1'b1; end
                            OP_MFHI: begin bus_sel_s[BS_HI] = 1'b1; reg_ld_s[LD_R] = 1'b1;   end
                            default: begin bus_sel_s[BS_LO] = 1'b1; reg_ld_s[LD_R] = 1'b1;   end
                        endcase
                    end
                    default: step_s = 3'd3;
                endcase
            end
            S_T4: begin
                step_s = 3'd4; running_s = 1'b1;
                case (cls_s)
                    C_LDI: begin
                        bus_sel_s[BS_C] = 1'b1; alu_op_s = ALU_ADD; reg_ld_s[LD_Z] = 1'b1;
                    end
                    C_RTYPE: begin
                        gr_sel_s[GR_C] = 1'b1; bus_sel_s[BS_R] = 1'b1;
                        alu_op_s = alu_s; reg_ld_s[LD_Z] = 1'b1;
                    end
                    C_IMM: begin
                        bus_sel_s[BS_C] = 1'b1; alu_op_s = alu_s; reg_ld_s[LD_Z] = 1'b1;
                    end
                    C_MULDIV: begin
                        gr_sel_s[GR_B] = 1'b1; bus_sel_s[BS_R] = 1'b1;
                        alu_op_s = alu_s; reg_ld_s[LD_Z] = 1'b1;
                    end
                    C_UNARY: begin
                        bus_sel_s[BS_ZLO] = 1'b1; gr_sel_s[GR_A] = 1'b1; reg_ld_s[LD_R] = 1'b1;
                    end
                    default: step_s = 3'd4;
                endcase
            end
            S_T5: begin
                step_s = 3'd5; running_s = 1'b1; bus_sel_s[BS_ZLO] = 1'b1;
                if (cls_s == C_MULDIV) begin
                    reg_ld_s[LD_LO] = 1'b1;
                end else begin
                    gr_sel_s[GR_A] = 1'b1; reg_ld_s[LD_R] = 1'b1;
                end
            end
            S_T6: begin
                step_s = 3'd6; running_s = 1'b1;
                bus_sel_s[BS_ZHI] = 1'b1; reg_ld_s[LD_HI] = 1'b1;
            end
            S_HALT:  halted_s = 1'b1;
            default: con_reset_s = 1'b1;
        endcase
    end

    assign cs.bus_sel   = bus_sel_s;
    assign cs.reg_ld    = reg_ld_s;
    assign cs.gr_sel    = gr_sel_s;
    assign cs.alu_op    = alu_op_s;
    assign cs.IncPC     = inc_pc_s;
    assign cs.Read      = read_s;
    assign cs.read_mem  = read_s;
    assign cs.CON_RESET = con_reset_s;
    assign cs.running   = running_s;
    assign cs.halted    = halted_s;
    assign cs.step      = step_s;
endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: every step's full control word is compared
// against a hand-built expected vector.
module tb_control_sequencer;
    localparam logic [9:0] B_BA = 10'h200, B_R = 10'h100, B_C = 10'h080, B_IN = 10'h040;
    localparam logic [9:0] B_MDR = 10'h020, B_ZLO = 10'h008, B_ZHI = 10'h004;
    localparam logic [9:0] B_LO = 10'h002, B_NONE = 10'h000;
    localparam logic [9:0] L_OUT = 10'h200, L_R = 10'h100, L_MDR = 10'h080, L_MAR = 10'h040;
    localparam logic [9:0] L_Y = 10'h020, L_Z = 10'h010, L_IR = 10'h008, L_PC = 10'h004;
    localparam logic [9:0] L_LO = 10'h002, L_HI = 10'h001, L_NONE = 10'h000;
    localparam logic [2:0] G_C = 3'b100, G_B = 3'b010, G_A = 3'b001, G_NONE = 3'b000;
    localparam logic [12:0] A_NEG = 13'h0800, A_MUL = 13'h0010, A_SUB = 13'h0008;
    localparam logic [12:0] A_ADD = 13'h0004, A_OR = 13'h0002, A_NONE = 13'h0000;
    // flags = {IncPC, Read, read_mem, CON_RESET, running, halted}
    localparam logic [5:0] F_INC = 6'b100000, F_RD = 6'b011000, F_CR = 6'b000100;
    localparam logic [5:0] F_RUN = 6'b000010, F_HLT = 6'b000001, F_NONE = 6'b000000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [44:0] obs;

    control_sequencer_if #(.OPW(5)) cs_if ();

    control_sequencer #(.OPW(5), .MULDIV_CYCLES(4), .MEM_TIMEOUT(0)) dut (
        .clk   (clk),
        .reset (reset),
        .cs    (cs_if)
    );

    always #5 clk = ~clk;

    assign obs = {cs_if.bus_sel, cs_if.reg_ld, cs_if.gr_sel, cs_if.alu_op, cs_if.IncPC,
                  cs_if.Read, cs_if.read_mem, cs_if.CON_RESET, cs_if.running, cs_if.halted,
                  cs_if.step};

    function automatic logic [44:0] ev(input logic [9:0] b, input logic [9:0] l,
                                       input logic [2:0] g, input logic [12:0] a,
                                       input logic [5:0] f, input logic [2:0] s);
        return {b, l, g, a, f, s};
    endfunction

    task automatic chk(input string tag, input logic [44:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and compare at the falling edge
    task automatic nxt(input string tag, input logic [44:0] exp);
        @(posedge clk);
        @(negedge clk);
        chk(tag, exp);
    endtask

    task automatic fetch(input logic [4:0] op);
        nxt("T0", ev(B_NONE, L_MAR | L_PC, G_NONE, A_NONE, F_INC | F_RUN, 3'd0));
        cs_if.ir_op = op;
        nxt("T1", ev(B_NONE, L_MDR, G_NONE, A_NONE, F_RD | F_RUN, 3'd1));
        nxt("T2", ev(B_MDR, L_IR, G_NONE, A_NONE, F_RUN, 3'd2));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before end of sequence");
        $fatal(1, "watchdog");
    end

    initial begin
        cs_if.run_in    = 1'b0;
        cs_if.mem_ready = 1'b0;
        cs_if.ir_op     = 5'b00000;

        // 1: reset and idle
        repeat (2) @(negedge clk);
        chk("reset", ev(B_NONE, L_NONE, G_NONE, A_NONE, F_CR, 3'd7));
        reset = 1'b0;
        #1;
        chk("rst_state", ev(B_NONE, L_NONE, G_NONE, A_NONE, F_CR, 3'd7));
        nxt("idle0", ev(B_NONE, L_NONE, G_NONE, A_NONE, F_NONE, 3'd7));
        nxt("idle1", ev(B_NONE, L_NONE, G_NONE, A_NONE, F_NONE, 3'd7));

        // 2: add, continuous run
        cs_if.run_in    = 1'b1;
        cs_if.mem_ready = 1'b1;
        fetch(5'b00011);
        nxt("add_T3", ev(B_R, L_Y, G_B, A_NONE, F_RUN, 3'd3));
        nxt("add_T4", ev(B_R, L_Z, G_C, A_ADD, F_RUN, 3'd4));
        nxt("add_T5", ev(B_ZLO, L_R, G_A, A_NONE, F_RUN, 3'd5));

        // 3: memory stall, ori
        nxt("ori_T0", ev(B_NONE, L_MAR | L_PC, G_NONE, A_NONE, F_INC | F_RUN, 3'd0));
        cs_if.mem_ready = 1'b0;
        cs_if.ir_op     = 5'b01110;
        for (int i = 0; i < 4; i++)
            nxt("stall_T1", ev(B_NONE, L_MDR, G_NONE, A_NONE, F_RD | F_RUN, 3'd1));
        cs_if.mem_ready = 1'b1;
        nxt("ori_T2", ev(B_MDR, L_IR, G_NONE, A_NONE, F_RUN, 3'd2));
        nxt("ori_T3", ev(B_R, L_Y, G_B, A_NONE, F_RUN, 3'd3));
        nxt("ori_T4", ev(B_C, L_Z, G_NONE, A_OR, F_RUN, 3'd4));
        nxt("ori_T5", ev(B_ZLO, L_R, G_A, A_NONE, F_RUN, 3'd5));

        // 4: mul with four ALU cycles
        fetch(5'b10000);
        nxt("mul_T3", ev(B_R, L_Y, G_A, A_NONE, F_RUN, 3'd3));
        for (int i = 0; i < 4; i++)
            nxt("mul_T4", ev(B_R, L_Z, G_B, A_MUL, F_RUN, 3'd4));
        nxt("mul_T5", ev(B_ZLO, L_LO, G_NONE, A_NONE, F_RUN, 3'd5));
        nxt("mul_T6", ev(B_ZHI, L_HI, G_NONE, A_NONE, F_RUN, 3'd6));

        // ldi, neg and in
        fetch(5'b00001);
        nxt("ldi_T3", ev(B_BA, L_Y, G_B, A_NONE, F_RUN, 3'd3));
        nxt("ldi_T4", ev(B_C, L_Z, G_NONE, A_ADD, F_RUN, 3'd4));
        nxt("ldi_T5", ev(B_ZLO, L_R, G_A, A_NONE, F_RUN, 3'd5));
        fetch(5'b10001);
        nxt("neg_T3", ev(B_R, L_Z, G_B, A_NEG, F_RUN, 3'd3));
        nxt("neg_T4", ev(B_ZLO, L_R, G_A, A_NONE, F_RUN, 3'd4));
        fetch(5'b10110);
        nxt("in_T3", ev(B_IN, L_R, G_A, A_NONE, F_RUN, 3'd3));
        fetch(5'b10111);
        nxt("out_T3", ev(B_R, L_OUT, G_A, A_NONE, F_RUN, 3'd3));
        fetch(5'b11010);
        nxt("nop_T3", ev(B_NONE, L_NONE, G_NONE, A_NONE, F_RUN, 3'd3));

        // 6: run_in drop mid-instruction, then reset mid-T4
        fetch(5'b00011);
        nxt("stop_T3", ev(B_R, L_Y, G_B, A_NONE, F_RUN, 3'd3));
        cs_if.run_in = 1'b0;
        nxt("stop_T4", ev(B_R, L_Z, G_C, A_ADD, F_RUN, 3'd4));
        nxt("stop_T5", ev(B_ZLO, L_R, G_A, A_NONE, F_RUN, 3'd5));
        nxt("stop_idle", ev(B_NONE, L_NONE, G_NONE, A_NONE, F_NONE, 3'd7));
        cs_if.run_in = 1'b1;
        fetch(5'b00100);
        nxt("sub_T3", ev(B_R, L_Y, G_B, A_NONE, F_RUN, 3'd3));
        nxt("sub_T4", ev(B_R, L_Z, G_C, A_SUB, F_RUN, 3'd4));
        reset = 1'b1;
        #1;
        chk("reset_T4", ev(B_NONE, L_NONE, G_NONE, A_NONE, F_CR, 3'd7));
        @(negedge clk);
        reset = 1'b0;
        nxt("post_rst_idle", ev(B_NONE, L_NONE, G_NONE, A_NONE, F_NONE, 3'd7));

        // 5: mflo then halt
        fetch(5'b11001);
        nxt("mflo_T3", ev(B_LO, L_R, G_A, A_NONE, F_RUN, 3'd3));
        fetch(5'b11011);
        nxt("halt_T3", ev(B_NONE, L_NONE, G_NONE, A_NONE, F_RUN, 3'd3));
        nxt("halted0", ev(B_NONE, L_NONE, G_NONE, A_NONE, F_HLT, 3'd7));
        cs_if.run_in = 1'b0;
        nxt("halted1", ev(B_NONE, L_NONE, G_NONE, A_NONE, F_HLT, 3'd7));
        cs_if.run_in = 1'b1;
        nxt("halted2", ev(B_NONE, L_NONE, G_NONE, A_NONE, F_HLT, 3'd7));
        nxt("halted3", ev(B_NONE, L_NONE, G_NONE, A_NONE, F_HLT, 3'd7));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
